// File: rtl/cmd_seq_pkg.sv
// Shared types for the command-script player: FSM states, error codes and the
// default positive-acknowledge byte.
package cmd_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND      = 3'd1,
        WAIT_SNT  = 3'd2,
        WAIT_RESP = 3'd3,
        CHECK     = 3'd4
    } seq_state_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_TMO   = 2'd1,
        ERR_NAK   = 2'd2,
        ERR_ABORT = 2'd3
    } seq_err_t;

    localparam logic [7:0] POS_ACK_DEF = 8'hA5;

endpackage

// File: rtl/cmd_seq_mem.sv
// Script storage: DEPTH x CMD_W register file, one write port, one
// combinational read port, cleared by the asynchronous reset.
module cmd_seq_mem
    import cmd_seq_pkg::*;
#(
    parameter int CMD_W = 16,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [CMD_W-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [CMD_W-1:0] rdata
);

    logic [CMD_W-1:0] mem_r [DEPTH];

    // Script entry write; reset empties the whole script
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/cmd_seq_player.sv
// Replayable command-script player driving RemoteComm's cmd/snd_cmd handshake.
// Define CMD_SEQ_RETRY_EN to resend a timed-out or NAKed command once before flagging it.
module cmd_seq_player
    import cmd_seq_pkg::*;
#(
    parameter int                CMD_W   = 16,
    parameter int                RESP_W  = 8,
    parameter int                DEPTH   = 8,
    parameter int                TMO_W   = 24,
    parameter logic [TMO_W-1:0]  TIMEOUT = 24'd1000000,
    parameter logic [RESP_W-1:0] POS_ACK = POS_ACK_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       load,
    input  logic [CMD_W-1:0]           load_cmd,
    output logic                       full,
    input  logic                       go,
    input  logic                       abort,
    output logic                       snd_cmd,
    output logic [CMD_W-1:0]           cmd,
    input  logic                       cmd_snt,
    input  logic                       resp_rdy,
    input  logic [RESP_W-1:0]          resp,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [1:0]                 err_code,
    output logic [$clog2(DEPTH)-1:0]   err_idx,
    output logic [$clog2(DEPTH):0]     n_cmds
);

    localparam int               AW       = $clog2(DEPTH);
    localparam logic [AW:0]      DEPTH_N  = (AW+1)'(DEPTH);
    localparam logic [AW:0]      N_ONE    = (AW+1)'(1'b1);
    localparam logic [AW-1:0]    IDX_ONE  = AW'(1'b1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1'b1);
    localparam logic [TMO_W-1:0] TMO_LAST = TIMEOUT - TMO_ONE;

    seq_state_t        state_r;
    seq_err_t          err_code_r;
    logic [AW-1:0]     idx_r;
    logic [AW-1:0]     err_idx_r;
    logic [AW:0]       n_cmds_r;
    logic [TMO_W-1:0]  tmo_r;
    logic [RESP_W-1:0] resp_r;
    logic [CMD_W-1:0]  cmd_r;
    logic              full_r;
    logic              snd_cmd_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;
    logic              we_s;
    logic              tmo_exp_s;
    logic [CMD_W-1:0]  rdata_s;
`ifdef CMD_SEQ_RETRY_EN
    logic              retry_r;
`endif

    // Script only changes while idle; clr beats a simultaneous load
    assign we_s      = (state_r == IDLE) && load && !clr && !full_r;
    assign tmo_exp_s = (tmo_r == TMO_LAST);

    cmd_seq_mem #(
        .CMD_W (CMD_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we_s),
        .waddr (n_cmds_r[AW-1:0]),
        .wdata (load_cmd),
        .raddr (idx_r),
        .rdata (rdata_s)
    );

    // Playback FSM with script bookkeeping, timeout counter and error capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            err_code_r <= ERR_NONE;
            idx_r      <= '0;
            err_idx_r  <= '0;
            n_cmds_r   <= '0;
            tmo_r      <= '0;
            resp_r     <= '0;
            cmd_r      <= '0;
            full_r     <= 1'b0;
            snd_cmd_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
`ifdef CMD_SEQ_RETRY_EN
            retry_r    <= 1'b0;
`endif
        end else begin
            snd_cmd_r <= 1'b0;
            done_r    <= 1'b0;
            if (abort && (state_r != IDLE)) begin
                state_r    <= IDLE;
                busy_r     <= 1'b0;
                err_r      <= 1'b1;
                err_code_r <= ERR_ABORT;
                err_idx_r  <= idx_r;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (clr) begin
                            n_cmds_r <= '0;
                            full_r   <= 1'b0;
                        end else if (load && !full_r) begin
                            n_cmds_r <= n_cmds_r + N_ONE;
                            full_r   <= ((n_cmds_r + N_ONE) == DEPTH_N);
                        end
                        if (go) begin
                            if (n_cmds_r == '0) begin
                                done_r <= 1'b1;
                            end else begin
                                state_r    <= SEND;
                                busy_r     <= 1'b1;
                                idx_r      <= '0;
                                err_r      <= 1'b0;
                                err_code_r <= ERR_NONE;
                                err_idx_r  <= '0;
`ifdef CMD_SEQ_RETRY_EN
                                retry_r    <= 1'b0;
`endif
                            end
                        end
                    end
                    SEND: begin
                        snd_cmd_r <= 1'b1;
                        cmd_r     <= rdata_s;
                        tmo_r     <= '0;
                        state_r   <= WAIT_SNT;
                    end
                    // A response on the expiry cycle still counts as a response
                    WAIT_SNT, WAIT_RESP: begin
                        if (resp_rdy) begin
                            resp_r  <= resp;
                            state_r <= CHECK;
                        end else if (tmo_exp_s) begin
`ifdef CMD_SEQ_RETRY_EN
                            if (!retry_r) begin
                                retry_r <= 1'b1;
                                state_r <= SEND;
                            end else
`endif
                            begin
                                state_r    <= IDLE;
                                busy_r     <= 1'b0;
                                err_r      <= 1'b1;
                                err_code_r <= ERR_TMO;
                                err_idx_r  <= idx_r;
                            end
                        end else begin
                            tmo_r <= tmo_r + TMO_ONE;
                            if ((state_r == WAIT_SNT) && cmd_snt) begin
                                state_r <= WAIT_RESP;
                            end
                        end
                    end
                    CHECK: begin
                        if (resp_r == POS_ACK) begin
`ifdef CMD_SEQ_RETRY_EN
                            retry_r <= 1'b0;
`endif
                            if (({1'b0, idx_r} + N_ONE) == n_cmds_r) begin
                                done_r  <= 1'b1;
                                busy_r  <= 1'b0;
                                idx_r   <= '0;
                                state_r <= IDLE;
                            end else begin
                                idx_r   <= idx_r + IDX_ONE;
                                state_r <= SEND;
                            end
`ifdef CMD_SEQ_RETRY_EN
                        end else if (!retry_r) begin
                            retry_r <= 1'b1;
                            state_r <= SEND;
`endif
                        end else begin
                            state_r    <= IDLE;
                            busy_r     <= 1'b0;
                            err_r      <= 1'b1;
                            err_code_r <= ERR_NAK;
                            err_idx_r  <= idx_r;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign full     = full_r;
    assign snd_cmd  = snd_cmd_r;
    assign cmd      = cmd_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign err      = err_r;
    assign err_code = err_code_r;
    assign err_idx  = err_idx_r;
    assign n_cmds   = n_cmds_r;

endmodule

// File: tb/tb_cmd_seq_player.sv
// Self-checking bench for cmd_seq_player: a cycle-scheduled script/response model
// plus literal checks; honours CMD_SEQ_RETRY_EN when the design is built with it.
module tb_cmd_seq_player;

    localparam int DEPTH = 8;
    localparam int TMO   = 100;
`ifdef CMD_SEQ_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, clr = 1'b0, load = 1'b0, go = 1'b0, abort = 1'b0;
    logic        cmd_snt = 1'b0, resp_rdy = 1'b0;
    logic [15:0] load_cmd = 16'h0;
    logic [7:0]  resp = 8'h0;
    logic        full, snd_cmd, busy, done, err;
    logic [15:0] cmd;
    logic [1:0]  err_code;
    logic [2:0]  err_idx;
    logic [3:0]  n_cmds;

    cmd_seq_player #(
        .CMD_W(16), .RESP_W(8), .DEPTH(DEPTH), .TMO_W(24),
        .TIMEOUT(24'd100), .POS_ACK(8'hA5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_cmd(load_cmd),
        .full(full), .go(go), .abort(abort), .snd_cmd(snd_cmd), .cmd(cmd),
        .cmd_snt(cmd_snt), .resp_rdy(resp_rdy), .resp(resp), .busy(busy),
        .done(done), .err(err), .err_code(err_code), .err_idx(err_idx), .n_cmds(n_cmds)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;

    // model: script contents and per-cycle scheduled output events
    logic [15:0] model_script[$];
    int snd_at[int];
    bit done_at[int];
    bit busy_on_at[int];
    int end_at[int];
    logic        exp_snd = 1'b0, exp_done = 1'b0, exp_busy = 1'b0, exp_err = 1'b0, exp_full = 1'b0;
    logic [15:0] exp_cmd = 16'h0;
    logic [1:0]  exp_code = 2'd0;
    logic [2:0]  exp_idx = 3'd0;
    logic [3:0]  exp_n = 4'd0;

    logic [7:0] resp_tab[DEPTH];
    int         rdly_tab[DEPTH];

    logic [15:0] obs_cmds[$];
    int   done_cnt = 0, last_snd_cyc = 0, err_rise_cyc = 0, d0 = 0;
    logic err_q = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [15:0] obs_at(input int i);
        if (i < obs_cmds.size()) return obs_cmds[i];
        return 16'hDEAD;
    endfunction

    // per-cycle comparison against the model, sampled mid-cycle
    always @(negedge clk) begin
        chk("snd_cmd", {31'd0, snd_cmd}, {31'd0, exp_snd});
        chk("cmd", {16'd0, cmd}, {16'd0, exp_cmd});
        chk("done", {31'd0, done}, {31'd0, exp_done});
        chk("busy", {31'd0, busy}, {31'd0, exp_busy});
        chk("err", {31'd0, err}, {31'd0, exp_err});
        chk("err_code", {30'd0, err_code}, {30'd0, exp_code});
        chk("err_idx", {29'd0, err_idx}, {29'd0, exp_idx});
        chk("n_cmds", {28'd0, n_cmds}, {28'd0, exp_n});
        chk("full", {31'd0, full}, {31'd0, exp_full});
        if (snd_cmd === 1'b1) begin
            obs_cmds.push_back(cmd);
            last_snd_cyc = cyc;
        end
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1 && err_q !== 1'b1) err_rise_cyc = cyc;
        err_q = err;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        exp_snd = snd_at.exists(cyc);
        if (exp_snd) exp_cmd = 16'(snd_at[cyc]);
        exp_done = done_at.exists(cyc);
        if (busy_on_at.exists(cyc)) begin
            exp_busy = 1'b1; exp_err = 1'b0; exp_code = 2'd0; exp_idx = 3'd0;
        end
        if (end_at.exists(cyc)) begin
            exp_busy = 1'b0;
            if (end_at[cyc] >= 0) begin
                exp_err  = 1'b1;
                exp_code = 2'(end_at[cyc] >> 4);
                exp_idx  = 3'(end_at[cyc] & 15);
            end
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1; load_cmd = v;
        tick();
        load = 1'b0;
        if (model_script.size() < DEPTH) model_script.push_back(v);
        exp_n    = 4'(model_script.size());
        exp_full = (model_script.size() == DEPTH);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        model_script.delete();
        exp_n = 4'd0; exp_full = 1'b0;
    endtask

    // run one playback; the bench acts as RemoteComm using resp_tab/rdly_tab
    // (rdly < 0: never respond); abort_k selects a command to abort in WAIT_RESP
    task automatic play(input int abort_k);
        int n, s, r, k, t;
        bit retried;
        n = model_script.size();
        go = 1'b1;
        if (n == 0) begin
            done_at[cyc+1] = 1'b1;
            tick();
            go = 1'b0;
            return;
        end
        busy_on_at[cyc+1] = 1'b1;
        s = cyc + 2; k = 0; retried = 1'b0;
        tick();
        go = 1'b0;
        forever begin
            snd_at[s] = int'(model_script[k]);
            if (k == abort_k) end_at[s+4] = (3 << 4) | k;
            if (rdly_tab[k] != 1) begin
                wait_until(s + 1);
                cmd_snt = 1'b1;
                tick();
                cmd_snt = 1'b0;
            end
            if (k == abort_k) begin
                wait_until(s + 3);
                abort = 1'b1;
                tick();
                abort = 1'b0;
                return;
            end
            if (rdly_tab[k] < 0) begin
                t = s + TMO;
                if (RETRY && !retried) begin
                    retried = 1'b1;
                    s = t + 1;
                    wait_until(t);
                    continue;
                end
                end_at[t] = (1 << 4) | k;
                wait_until(t);
                return;
            end
            r = s + rdly_tab[k];
            wait_until(r);
            resp_rdy = 1'b1; resp = resp_tab[k];
            tick();
            resp_rdy = 1'b0;
            if (resp_tab[k] == 8'hA5) begin
                retried = 1'b0;
                k++;
                if (k == n) begin
                    done_at[r+2] = 1'b1;
                    end_at[r+2]  = -1;
                    wait_until(r + 2);
                    return;
                end
                s = r + 3;
            end else if (RETRY && !retried) begin
                retried = 1'b1;
                s = r + 3;
            end else begin
                end_at[r+2] = (2 << 4) | k;
                wait_until(r + 2);
                return;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin resp_tab[i] = 8'hA5; rdly_tab[i] = 3; end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rst_n_cmds", {28'd0, n_cmds}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err_code", {30'd0, err_code}, 32'd0);

        // two-command script, all acknowledged
        do_load(16'h6000); do_load(16'h7044);
        obs_cmds.delete(); d0 = done_cnt;
        play(-1); tick();
        chk("t1_sends", obs_cmds.size(), 32'd2);
        chk("t1_cmd0", {16'd0, obs_at(0)}, 32'h6000);
        chk("t1_cmd1", {16'd0, obs_at(1)}, 32'h7044);
        chk("t1_done", done_cnt - d0, 32'd1);
        chk("t1_err", {31'd0, err}, 32'd0);

        // abort while idle does nothing
        abort = 1'b1; tick(); abort = 1'b0; tick();

        // NAK on the second of three commands
        do_clr();
        do_load(16'h1111); do_load(16'h2222); do_load(16'h3333);
        resp_tab[1] = 8'h5A;
        obs_cmds.delete();
        play(-1); tick();
        chk("t2_err", {31'd0, err}, 32'd1);
        chk("t2_code", {30'd0, err_code}, 32'd2);
        chk("t2_idx", {29'd0, err_idx}, 32'd1);
        chk("t2_sends", obs_cmds.size(), RETRY ? 32'd3 : 32'd2);

        // response on the expiry cycle wins; response accepted in WAIT_SNT
        resp_tab[1] = 8'hA5;
        rdly_tab[0] = 99; rdly_tab[1] = 1; rdly_tab[2] = 3;
        obs_cmds.delete(); d0 = done_cnt;
        play(-1); tick();
        chk("t3_err", {31'd0, err}, 32'd0);
        chk("t3_done", done_cnt - d0, 32'd1);
        chk("t3_sends", obs_cmds.size(), 32'd3);

        // no response at all: timeout TIMEOUT cycles after the strobe
        rdly_tab[0] = -1;
        obs_cmds.delete();
        play(-1); tick();
        chk("t4_code", {30'd0, err_code}, 32'd1);
        chk("t4_idx", {29'd0, err_idx}, 32'd0);
        chk("t4_latency", err_rise_cyc - last_snd_cyc, 32'd100);
        chk("t4_sends", obs_cmds.size(), RETRY ? 32'd2 : 32'd1);

        // abort in WAIT_RESP of command 2, then replay from entry 0
        for (int i = 0; i < DEPTH; i++) rdly_tab[i] = 3;
        obs_cmds.delete();
        play(2); tick();
        chk("t5_code", {30'd0, err_code}, 32'd3);
        chk("t5_idx", {29'd0, err_idx}, 32'd2);
        obs_cmds.delete(); d0 = done_cnt;
        play(-1); tick();
        chk("t5_replay_cmd0", {16'd0, obs_at(0)}, 32'h1111);
        chk("t5_replay_err", {31'd0, err}, 32'd0);
        chk("t5_replay_done", done_cnt - d0, 32'd1);

        // fill beyond DEPTH, clear, empty go
        do_clr();
        for (int i = 0; i < DEPTH; i++) do_load(16'hC000 + 16'(i));
        chk("t6_full", {31'd0, full}, 32'd1);
        do_load(16'hBEEF);
        chk("t6_n_cmds", {28'd0, n_cmds}, 32'd8);
        do_clr();
        chk("t6_clr", {28'd0, n_cmds}, 32'd0);
        obs_cmds.delete(); d0 = done_cnt;
        play(-1); tick();
        chk("t6_empty_done", done_cnt - d0, 32'd1);
        chk("t6_empty_sends", obs_cmds.size(), 32'd0);

        // asynchronous reset during WAIT_SNT
        do_load(16'hAAAA); do_load(16'hBBBB);
        d0 = done_cnt;
        go = 1'b1;
        busy_on_at[cyc+1] = 1'b1;
        snd_at[cyc+2] = 32'hAAAA;
        tick(); go = 1'b0;
        tick(); tick();
        #2;
        rst_n = 1'b0;
        snd_at.delete(); done_at.delete(); busy_on_at.delete(); end_at.delete();
        model_script.delete();
        exp_snd = 1'b0; exp_done = 1'b0; exp_busy = 1'b0; exp_err = 1'b0; exp_full = 1'b0;
        exp_cmd = 16'h0; exp_code = 2'd0; exp_idx = 3'd0; exp_n = 4'd0;
        #1;
        chk("t7_busy", {31'd0, busy}, 32'd0);
        chk("t7_cmd", {16'd0, cmd}, 32'd0);
        chk("t7_n_cmds", {28'd0, n_cmds}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("t7_no_done", done_cnt - d0, 32'd0);
        chk("t7_err", {31'd0, err}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
